// File: rtl/twiddle_seq.sv
// -----------------------------------------------------------------------------
// twiddle_seq
//
// Streams the radix-2 decimation-in-time twiddle factors W_N^k needed by one
// FFT stage. Each accepted start emits exactly N/2 elements. The elements are
// ordered by butterfly index b = 0..N/2-1, and each element carries
// k = (b mod 2^s) * 2^(LOG2N-1-s).
//
// The cos/sin values are read from a quarter-wave sine table. The table is
// computed once at elaboration and never written at run time. The rest of the
// wave is rebuilt from that quarter using the usual symmetry rules.
//
// Ports
//    clk        sole clock, rising edge
//    rst        synchronous active-high reset
//    start      one-cycle request for one stage's sequence (sampled in IDLE)
//    stage      DIT stage number, sampled together with start
//    busy       high from the accepted start until done
//    out_valid  out_re/out_im/out_k/out_last hold a valid element
//    out_ready  consumer accepts the element when out_valid && out_ready
//    out_re     real part of W_N^k, twos-complement with FRAC fraction bits
//    out_im     imaginary part of W_N^k
//    out_k      twiddle exponent k, 0..N/2-1
//    out_last   marks the final element (b = N/2-1)
//    done       one-cycle pulse after the final handshake
//    err        one-cycle pulse when a start arrives with stage >= LOG2N
// -----------------------------------------------------------------------------
module twiddle_seq #(
   parameter int WIDTH = 16,
   parameter int LOG2N = 4,
   parameter int FRAC  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       stage,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_re,
   output logic [WIDTH-1:0] out_im,
   output logic [LOG2N-2:0] out_k,
   output logic             out_last,
   output logic             done,
   output logic             err
);

   localparam int  KW      = LOG2N - 1;
   localparam int  HALF    = 1 << KW;
   localparam int  QUARTER = 1 << (LOG2N - 2);
   localparam real PI      = 3.14159265358979323846;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   state_t                  state;
   logic [3:0]              stageReg;
   logic [KW-1:0]           bCount;
   logic                    genDone;
   logic [KW-1:0]           kA;
   logic                    lastA;
   logic                    validA;
   logic                    advance;
   logic [KW-1:0]           kNext;
   logic [KW-1:0]           idxRe;
   logic [KW-1:0]           idxIm;
   logic signed [WIDTH-1:0] twRe;
   logic signed [WIDTH-1:0] twIm;
   logic signed [WIDTH-1:0] sinTab [0:QUARTER];

   // Table entry i is round(2^FRAC * sin(pi*i/(N/2))), rounded half away from
   // zero. Every angle lies in [0, pi/2], so a short Taylor series is far more
   // accurate than the LSB we round to. Using the series avoids any reliance
   // on tool support for real math system functions. All entries are
   // non-negative, so adding 0.5 and truncating gives the required rounding.
   function automatic int sinEntry(input int i);
      real x;
      real term;
      real sum;
      x    = PI * real'(i) / real'(HALF);
      term = x;
      sum  = x;
      for (int n = 1; n < 12; n++) begin
         term = -term * x * x / real'((2 * n) * (2 * n + 1));
         sum  = sum + term;
      end
      return $rtoi(sum * real'(1 << FRAC) + 0.5);
   endfunction

   // The quarter-wave table is made of constants only. Each entry is fixed at
   // elaboration, so synthesis folds the whole table into the lookup muxes.
   for (genvar g = 0; g <= QUARTER; g++) begin : gSinTab
      assign sinTab[g] = WIDTH'(sinEntry(g));
   end

   // Both pipeline registers move together whenever the output register is
   // empty or is being consumed. A stall freezes the whole chain, so no
   // element is dropped or duplicated, and there are no bubbles while
   // out_ready stays high.
   assign advance = !out_valid || out_ready;

   // Build the exponent for butterfly bCount. The mask keeps the low s bits
   // (b mod 2^s), and the shift scales by 2^(LOG2N-1-s). When s equals KW,
   // 1 << s minus one still truncates to an all-ones KW-bit mask, which is
   // the intended result.
   always_comb begin
      kNext = '0;
      kNext = (bCount & KW'((1 << stageReg) - 1)) << (KW - int'(stageReg));
   end

   // Rebuild W_N^k = cos - j*sin from the quarter-wave table.
   // For k up to N/4, cos comes from the mirrored index (Q - k).
   // Past N/4, cos is the negated sine of (k - Q), and sin is read from
   // (N/2 - k). The integer arithmetic keeps N/2 - k correct even though
   // N/2 itself does not fit in KW bits.
   always_comb begin
      idxRe = '0;
      idxIm = '0;
      twRe  = '0;
      twIm  = '0;
      if (int'(kA) <= QUARTER) begin
         idxRe = KW'(QUARTER - int'(kA));
         idxIm = kA;
         twRe  = sinTab[idxRe];
         twIm  = -sinTab[idxIm];
      end else begin
         idxRe = KW'(int'(kA) - QUARTER);
         idxIm = KW'(HALF - int'(kA));
         twRe  = -sinTab[idxRe];
         twIm  = -sinTab[idxIm];
      end
   end

   // Sequencer FSM with every output registered.
   //
   // IDLE: accepts a start. A start is ignored during the done cycle, so a
   // new request can only land one cycle later.
   //
   // RUN: a generator walks b from 0 to N/2-1 into pipeline register A
   // (k, last flag). The table lookup then loads the output register from
   // A. This two-register chain is what puts the first element on the output
   // two edges after the start.
   //
   // When the last element reaches the output register, the FSM moves to
   // DRAIN. There it only waits for the final handshake, then pulses done and
   // drops busy.
   //
   // An out-of-range stage is clamped to the final stage and flags err once.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         stageReg  <= '0;
         bCount    <= '0;
         genDone   <= 1'b0;
         kA        <= '0;
         lastA     <= 1'b0;
         validA    <= 1'b0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_k     <= '0;
         out_last  <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !done) begin
                  state   <= RUN;
                  busy    <= 1'b1;
                  bCount  <= '0;
                  genDone <= 1'b0;
                  validA  <= 1'b0;
                  if (int'(stage) >= LOG2N) begin
                     stageReg <= 4'(LOG2N - 1);
                     err      <= 1'b1;
                  end else begin
                     stageReg <= stage;
                  end
               end
            end
            RUN: begin
               if (advance) begin
                  out_valid <= validA;
                  if (validA) begin
                     out_re   <= twRe;
                     out_im   <= twIm;
                     out_k    <= kA;
                     out_last <= lastA;
                  end
                  if (validA && lastA) begin
                     state <= DRAIN;
                  end
                  if (genDone) begin
                     validA <= 1'b0;
                  end else begin
                     validA <= 1'b1;
                     kA     <= kNext;
                     lastA  <= &bCount;
                     if (&bCount) begin
                        genDone <= 1'b1;
                     end else begin
                        bCount <= bCount + 1'b1;
                     end
                  end
               end
            end
            DRAIN: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_twiddle_seq.sv
// -----------------------------------------------------------------------------
// tb_twiddle_seq
//
// Self-checking bench for twiddle_seq at N=16, FRAC=8, WIDTH=16.
//
// The reference model computes each expected element directly from
// cos/sin of 2*pi*k/N, rounded half away from zero. The k sequence comes from
// the butterfly rule for the requested stage.
//
// Directed runs cover the listed stage cases. Further runs use random
// stages, random out_ready backpressure and random starts while busy.
// -----------------------------------------------------------------------------
module tb_twiddle_seq;

   localparam int  WIDTH = 16;
   localparam int  LOG2N = 4;
   localparam int  FRAC  = 8;
   localparam int  N     = 1 << LOG2N;
   localparam int  HALF  = N / 2;
   localparam real PI    = 3.14159265358979323846;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [3:0]       stage;
   logic             busy;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_re;
   logic [WIDTH-1:0] out_im;
   logic [LOG2N-2:0] out_k;
   logic             out_last;
   logic             done;
   logic             err;

   int checks = 0;
   int errors = 0;

   int expRe[$];
   int expIm[$];
   int expK[$];
   int expLast[$];

   twiddle_seq #(
      .WIDTH(WIDTH),
      .LOG2N(LOG2N),
      .FRAC (FRAC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stage    (stage),
      .busy     (busy),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_re   (out_re),
      .out_im   (out_im),
      .out_k    (out_k),
      .out_last (out_last),
      .done     (done),
      .err      (err)
   );

   // Free-running clock with a 10 time-unit period.
   always #5 clk = ~clk;

   // Hard stop in case something wedges far beyond any legitimate run length.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Round half away from zero.
   function automatic int roundAway(input real v);
      if (v >= 0.0) begin
         return $rtoi(v + 0.5);
      end
      return -$rtoi(-v + 0.5);
   endfunction

   // Reference sequence for one start. Out-of-range stages run as the last
   // stage. Each element's twiddle is computed straight from cos/sin.
   function automatic void buildExpected(input int s);
      int  se;
      int  k;
      real ang;
      real scale;
      expRe.delete();
      expIm.delete();
      expK.delete();
      expLast.delete();
      se    = (s >= LOG2N) ? LOG2N - 1 : s;
      scale = 2.0 ** FRAC;
      for (int b = 0; b < HALF; b++) begin
         k   = (b % (1 << se)) * (1 << (LOG2N - 1 - se));
         ang = 2.0 * PI * real'(k) / real'(N);
         expK.push_back(k);
         expRe.push_back(roundAway(scale * $cos(ang)));
         expIm.push_back(-roundAway(scale * $sin(ang)));
         expLast.push_back((b == HALF - 1) ? 1 : 0);
      end
   endfunction

   // Every output must read zero after a reset edge.
   task automatic checkResetState(input string tag);
      checkOutput({tag, "_busy"},      int'(busy),      0);
      checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
      checkOutput({tag, "_out_last"},  int'(out_last),  0);
      checkOutput({tag, "_done"},      int'(done),      0);
      checkOutput({tag, "_err"},       int'(err),       0);
      checkOutput({tag, "_out_re"},    int'(out_re),    0);
      checkOutput({tag, "_out_im"},    int'(out_im),    0);
      checkOutput({tag, "_out_k"},     int'(out_k),     0);
   endtask

   // Issue one start and follow the whole sequence.
   //
   // Inputs change and outputs are sampled on the falling edge. Each
   // handshake is compared against the model. Stalled cycles must hold every
   // output. Latency, err pulse count, handshake count and done timing are
   // checked at the end.
   //
   // Options:
   //    pokeStage >= 0  re-asserts start mid-sequence with that stage
   //    abortAfter > 0  applies rst right after that many handshakes
   //    startInDone     drives start during the done cycle
   task automatic applyStimulus(input int stg, input int readyPct, input int pokeStage,
                                input int abortAfter, input bit startInDone);
      int    e;
      int    hs;
      int    errPulses;
      int    firstValid;
      int    lastHsEdge;
      int    doneEdge;
      int    expErr;
      int    total;
      int    doneAfterAbort;
      bit    stalled;
      int    pRe;
      int    pIm;
      int    pK;
      int    pLast;
      string tg;

      tg = $sformatf("s%0d", stg);
      buildExpected(stg);
      total          = expK.size();
      expErr         = (stg >= LOG2N) ? 1 : 0;
      e              = 0;
      hs             = 0;
      errPulses      = 0;
      firstValid     = -1;
      lastHsEdge     = -1;
      doneEdge       = -1;
      doneAfterAbort = 0;
      stalled        = 1'b0;
      pRe            = 0;
      pIm            = 0;
      pK             = 0;
      pLast          = 0;

      start     = 1'b1;
      stage     = 4'(stg);
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;

      while (doneEdge < 0 && e < 200) begin
         if (abortAfter > 0 && hs == abortAfter) begin
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            checkResetState({tg, "_abort"});
            for (int i = 0; i < 4; i++) begin
               @(posedge clk);
               @(negedge clk);
               doneAfterAbort += int'(done) + int'(out_valid);
            end
            checkOutput({tg, "_quiet_after_abort"}, doneAfterAbort, 0);
            return;
         end
         if (err) begin
            errPulses++;
         end
         if (out_valid && firstValid < 0) begin
            firstValid = e;
            checkOutput({tg, "_busy_with_first"}, int'(busy), 1);
         end
         if (stalled) begin
            checkOutput({tg, "_hold_valid"}, int'(out_valid), 1);
            checkOutput({tg, "_hold_re"}, int'($signed(out_re)), pRe);
            checkOutput({tg, "_hold_im"}, int'($signed(out_im)), pIm);
            checkOutput({tg, "_hold_k"}, int'(out_k), pK);
            checkOutput({tg, "_hold_last"}, int'(out_last), pLast);
         end
         if (done) begin
            doneEdge = e;
            checkOutput({tg, "_busy_at_done"}, int'(busy), 0);
            checkOutput({tg, "_valid_at_done"}, int'(out_valid), 0);
         end else begin
            if (pokeStage >= 0) begin
               start = (e == 4);
               stage = 4'(pokeStage);
            end
            out_ready = (int'($urandom_range(99, 0)) < readyPct);
            stalled   = out_valid && !out_ready;
            pRe       = int'($signed(out_re));
            pIm       = int'($signed(out_im));
            pK        = int'(out_k);
            pLast     = int'(out_last);
            if (out_valid && out_ready) begin
               if (expK.size() == 0) begin
                  checkOutput({tg, "_extra_element"}, hs + 1, total);
               end else begin
                  checkOutput($sformatf("%s_re_%0d", tg, hs), pRe, expRe.pop_front());
                  checkOutput($sformatf("%s_im_%0d", tg, hs), pIm, expIm.pop_front());
                  checkOutput($sformatf("%s_k_%0d", tg, hs), pK, expK.pop_front());
                  checkOutput($sformatf("%s_last_%0d", tg, hs), pLast, expLast.pop_front());
               end
               hs++;
               lastHsEdge = e + 1;
            end
            @(posedge clk);
            @(negedge clk);
            e++;
         end
      end
      start = 1'b0;

      checkOutput({tg, "_done_seen"}, int'(doneEdge >= 0), 1);
      checkOutput({tg, "_handshakes"}, hs, total);
      checkOutput({tg, "_err_pulses"}, errPulses, expErr);
      checkOutput({tg, "_first_latency"}, firstValid, 2);
      checkOutput({tg, "_done_after_last"}, doneEdge, lastHsEdge);
      if (readyPct >= 100) begin
         checkOutput({tg, "_no_bubbles"}, doneEdge, 2 + total);
      end

      if (startInDone) begin
         start = 1'b1;
         stage = 4'd0;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checkOutput({tg, "_done_one_cycle"}, int'(done), 0);
      if (startInDone) begin
         checkOutput({tg, "_start_in_done_ignored"}, int'(busy), 0);
      end
   endtask

   // Test sequence.
   //
   // Directed runs come first: reset, then stages 0, 3 and 1 with constant
   // ready, stage 3 under random backpressure (with a start in its done
   // cycle), the out-of-range stage with a start while busy, a mid-sequence
   // reset, and a fresh stage 2 run.
   //
   // Randomised runs follow.
   initial begin
      int rs;
      int rp;
      int pk;

      rst       = 1'b1;
      start     = 1'b0;
      stage     = 4'd0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetState("reset");
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);

      applyStimulus(0, 100, -1, 0, 1'b0);
      applyStimulus(3, 100, -1, 0, 1'b0);
      applyStimulus(1, 100, -1, 0, 1'b0);
      applyStimulus(3, 50, -1, 0, 1'b1);
      applyStimulus(5, 100, 9, 0, 1'b0);
      applyStimulus(3, 100, -1, 3, 1'b0);
      applyStimulus(2, 100, -1, 0, 1'b0);

      for (int r = 0; r < 8; r++) begin
         rs = int'($urandom_range(15, 0));
         rp = int'($urandom_range(100, 30));
         pk = ($urandom_range(1, 0) == 1) ? int'($urandom_range(15, 0)) : -1;
         applyStimulus(rs, rp, pk, 0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/twiddle_seq.md
TWIDDLE_SEQ -- requirements
Module: twiddle_seq

Parameters
REQ-001 WIDTH, default 16, twos-complement width of each twiddle component.
REQ-002 LOG2N, default 4, log2 of FFT size N; legal range 3..10.
REQ-003 FRAC, default 8, fractional bits; +1.0 encodes as 2^FRAC; FRAC <= WIDTH-2.

Interface
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle request to emit one stage's twiddle sequence.
REQ-007 stage  in  4  radix-2 DIT stage number, sampled with start.
REQ-008 busy  out  1  high from accepted start until done.
REQ-009 out_valid  out  1  out_re/out_im/out_k/out_last valid.
REQ-010 out_ready  in  1  consumer accepts when out_valid && out_ready.
REQ-011 out_re  out  WIDTH  real part of W_N^k.
REQ-012 out_im  out  WIDTH  imaginary part of W_N^k.
REQ-013 out_k  out  LOG2N-1  twiddle exponent k, 0..N/2-1.
REQ-014 out_last  out  1  marks final element of sequence.
REQ-015 done  out  1  one-cycle pulse after last handshake.
REQ-016 err  out  1  one-cycle pulse on accepted start with stage >= LOG2N.

Function
REQ-017 Twiddle definition: W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), k in 0..N/2-1.
REQ-018 Internal quarter-wave table T[i] = round(2^FRAC * sin(pi*i/(N/2))), i = 0..N/4, round half away from zero, fixed at elaboration; no runtime writes.
REQ-019 With Q = N/4: k <= Q -> re = T[Q-k], im = -T[k]; k > Q -> re = -T[k-Q], im = -T[N/2-k]; results sign-extended to WIDTH.
REQ-020 Sequence for stage s: butterflies b = 0..N/2-1 in ascending order; k = (b mod 2^s) * 2^(LOG2N-1-s); exactly N/2 elements per start.
REQ-021 stage >= LOG2N: err pulses in cycle after start; sequence runs as s = LOG2N-1.
REQ-022 FSM states IDLE, RUN, DRAIN: IDLE --start--> RUN; RUN --last element loaded into output register--> DRAIN; DRAIN --last handshake--> IDLE.
REQ-023 start sampled only in IDLE; start while busy ignored, no effect on sequence or err.
REQ-024 Latency: start sampled at edge E0 -> busy high and first element on out_valid after edge E2 (two cycles).
REQ-025 Throughput: one element per cycle while out_ready high; no bubbles between elements.
REQ-026 Backpressure: out_valid && !out_ready -> out_re, out_im, out_k, out_last held stable; no element dropped or duplicated.
REQ-027 out_valid, once high, falls only after a handshake.
REQ-028 out_last high only with the element b = N/2-1.
REQ-029 done pulses in cycle after last handshake; busy falls in same cycle; a start in that cycle is ignored; a start in the next cycle is accepted.

Reset
REQ-030 rst high at edge: FSM -> IDLE; busy, out_valid, out_last, done, err = 0; out_re, out_im, out_k = 0.
REQ-031 rst mid-sequence aborts it; no done pulse; next start after rst release starts a fresh sequence from b = 0.
REQ-032 rst dominates start on the same edge.

Verification (N=16, FRAC=8, WIDTH=16; T = 0, 98, 181, 237, 256)
REQ-033 start, stage=0, out_ready=1 -> 8 elements, all k=0, (256, 0); out_last on 8th; done one cycle after that.
REQ-034 start, stage=3, out_ready=1 -> k = 0..7: (256,0), (237,-98), (181,-181), (98,-237), (0,-256), (-98,-237), (-181,-181), (-237,-98).
REQ-035 start, stage=1 -> k = 0,4,0,4,0,4,0,4 alternating (256,0) and (0,-256).
REQ-036 stage=3 with out_ready randomly low (~50%) -> same 8 elements in order, outputs stable while stalled, total handshakes = 8.
REQ-037 start with stage=5 -> err pulse once; sequence identical to the stage=3 case; start reasserted while busy -> ignored, still exactly 8 elements.
REQ-038 rst after 3rd handshake -> all outputs 0 next cycle, no done; new start stage=2 -> k = 0,2,4,6,0,2,4,6 from the beginning.
